// File: rtl/factorial_unit_pkg.sv
// Shared integer types, FSM state encoding and default widths for the factorial path.
package int_types;

   typedef logic [3:0]  INT04_t;
   typedef logic [40:0] INT41_t;

   localparam int unsigned FACT_OP_W_DEF   = $bits(INT04_t);
   localparam int unsigned FACT_PROD_W_DEF = $bits(INT41_t);

   typedef enum logic [1:0] {
      IDLE,
      ACC,
      DONE
   } fact_state_t;

endpackage

// File: rtl/factorial_unit_mul_step.sv
// One combinational multiply step: product*term truncated to PROD_W, plus overflow bit.
// Overflow detection exists only when FACTORIAL_UNIT_OVF_EN is defined.
module fact_mul_step
   import int_types::*;
#(
   parameter int unsigned OP_W   = FACT_OP_W_DEF,
   parameter int unsigned PROD_W = FACT_PROD_W_DEF
) (
   input  logic [PROD_W-1:0] product,
   input  logic [OP_W-1:0]   term,
   output logic [PROD_W-1:0] next_product,
   output logic              ovf
);

`ifdef FACTORIAL_UNIT_OVF_EN
   logic [PROD_W+OP_W-1:0] full;

   assign full         = {{OP_W{1'b0}}, product} * {{PROD_W{1'b0}}, term};
   assign next_product = full[PROD_W-1:0];
   assign ovf          = |full[PROD_W+OP_W-1:PROD_W];
`else
   // Product-width context keeps only the low bits, so no upper bits are built.
   assign next_product = product * {{(PROD_W-OP_W){1'b0}}, term};
   assign ovf          = 1'b0;
`endif

endmodule

// File: rtl/factorial_unit.sv
// Handshaked iterative n! engine: IDLE -> ACC (one multiply per cycle) -> DONE.
// FACTORIAL_UNIT_OVF_EN enables sticky overflow tracking; otherwise out_ovf is 0.
module factorial_unit
   import int_types::*;
#(
   parameter int unsigned OP_W   = FACT_OP_W_DEF,
   parameter int unsigned PROD_W = FACT_PROD_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [OP_W-1:0]   in_operand,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PROD_W-1:0] out_product,
   output logic              out_ovf,
   output logic              busy
);

   fact_state_t       state;
   logic [OP_W-1:0]   term;
   logic [PROD_W-1:0] product;
   logic [PROD_W-1:0] step_product;
   logic              step_ovf;

   fact_mul_step #(
      .OP_W   (OP_W),
      .PROD_W (PROD_W)
   ) u_step (
      .product      (product),
      .term         (term),
      .next_product (step_product),
      .ovf          (step_ovf)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         term    <= '0;
         product <= PROD_W'(1);
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  term    <= in_operand;
                  product <= PROD_W'(1);
                  state   <= ACC;
               end
            end
            ACC: begin
               if (term <= OP_W'(1)) begin
                  state <= DONE;
               end else begin
                  product <= step_product;
                  term    <= term - OP_W'(1);
               end
            end
            DONE: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef FACTORIAL_UNIT_OVF_EN
   logic ovf;

   always_ff @(posedge clk) begin
      if (rst) begin
         ovf <= 1'b0;
      end else if (state == IDLE && in_valid) begin
         ovf <= 1'b0;
      end else if (state == ACC && term > OP_W'(1)) begin
         ovf <= ovf | step_ovf;
      end
   end

   assign out_ovf = ovf;
`else
   assign out_ovf = step_ovf;
`endif

   assign in_ready    = (state == IDLE);
   assign out_valid   = (state == DONE);
   assign busy        = (state != IDLE);
   assign out_product = product;

endmodule

// File: tb/tb_factorial_unit.sv
// Scoreboard bench for factorial_unit: directed operands, expected results queued at accept.
// A second instance with PROD_W=16 exercises truncation and overflow.
module tb_factorial_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_operand;
   logic        out_valid;
   logic        out_ready;
   logic [40:0] out_product;
   logic        out_ovf;
   logic        busy;

   logic        v16;
   logic        in_ready16;
   logic [3:0]  op16;
   logic        out_valid16;
   logic        out_ready16;
   logic [15:0] prod16;
   logic        out_ovf16;
   logic        busy16;

   typedef struct {
      logic [63:0] prod;
      logic        ovf;
      int          acc;
      int          lat;
   } exp_t;

   exp_t q[$];
   exp_t q16[$];

   int cyc    = 0;
   int checks = 0;
   int errors = 0;

`ifdef FACTORIAL_UNIT_OVF_EN
   localparam logic OVF_EN = 1'b1;
`else
   localparam logic OVF_EN = 1'b0;
`endif

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   factorial_unit dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_operand  (in_operand),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_product (out_product),
      .out_ovf     (out_ovf),
      .busy        (busy)
   );

   factorial_unit #(
      .OP_W   (4),
      .PROD_W (16)
   ) dut16 (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (v16),
      .in_ready    (in_ready16),
      .in_operand  (op16),
      .out_valid   (out_valid16),
      .out_ready   (out_ready16),
      .out_product (prod16),
      .out_ovf     (out_ovf16),
      .busy        (busy16)
   );

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic issue(input logic [3:0] n, input logic [63:0] p, input bit track);
      int t;
      t          = 0;
      in_operand = n;
      in_valid   = 1'b1;
      while (!in_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (t >= 200) chk("accept_timeout", 1, 0);
      if (track) q.push_back('{p, 1'b0, cyc + 1, (n <= 1) ? 1 : int'(n)});
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_done();
      int t;
      t = 0;
      while (!out_valid && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (t >= 100) chk("done_timeout", 1, 0);
      @(negedge clk);
      chk("in_ready_after_hs", in_ready, 1);
      chk("busy_after_hs", busy, 0);
   endtask

   // Monitor for the default-width unit
   logic        pv      = 1'b0;
   logic        held_ok = 1'b0;
   logic [63:0] held_p;
   logic        held_o;

   always @(negedge clk) begin : mon
      exp_t e;
      if (!rst && out_valid) begin
         if (!pv) begin
            if (q.size() == 0) begin
               chk("unexpected_output", 1, 0);
               held_ok <= 1'b0;
            end else begin
               e = q.pop_front();
               chk("product", out_product, e.prod);
               chk("ovf", out_ovf, e.ovf);
               chk("latency", cyc - e.acc, e.lat);
               held_p  <= e.prod;
               held_o  <= e.ovf;
               held_ok <= 1'b1;
            end
         end else if (held_ok) begin
            chk("held_product", out_product, held_p);
            chk("held_ovf", out_ovf, held_o);
         end
      end
      pv <= out_valid && !rst;
   end

   // Monitor for the 16-bit unit
   logic pv16 = 1'b0;

   always @(negedge clk) begin : mon16
      exp_t e;
      if (!rst && out_valid16 && !pv16) begin
         if (q16.size() == 0) begin
            chk("unexpected_output16", 1, 0);
         end else begin
            e = q16.pop_front();
            chk("product16", prod16, e.prod);
            chk("ovf16", out_ovf16, e.ovf);
            chk("latency16", cyc - e.acc, e.lat);
         end
      end
      pv16 <= out_valid16 && !rst;
   end

   initial begin
      int t;
      rst         = 1'b1;
      in_valid    = 1'b0;
      in_operand  = '0;
      out_ready   = 1'b1;
      v16         = 1'b0;
      op16        = '0;
      out_ready16 = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_product", out_product, 1);
      chk("rst_ovf", out_ovf, 0);
      chk("rst_in_ready16", in_ready16, 1);
      rst = 1'b0;
      @(negedge clk);

      issue(4'd5, 64'd120, 1'b1);
      wait_done();
      issue(4'd0, 64'd1, 1'b1);
      wait_done();
      issue(4'd1, 64'd1, 1'b1);
      wait_done();
      issue(4'd15, 64'd1307674368000, 1'b1);
      wait_done();

      // Consumer stalls; a second offer during DONE must be ignored.
      out_ready = 1'b0;
      issue(4'd4, 64'd24, 1'b1);
      t = 0;
      while (!out_valid && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (t >= 100) chk("stall_timeout", 1, 0);
      in_operand = 4'd7;
      in_valid   = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("stall_out_valid", out_valid, 1);
         chk("stall_in_ready", in_ready, 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("stall_release_in_ready", in_ready, 1);
      chk("stall_release_out_valid", out_valid, 0);

      // Reset lands on the third ACC edge of an n=10 job.
      issue(4'd10, 64'd0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_in_ready", in_ready, 1);
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_product", out_product, 1);
      chk("midrst_ovf", out_ovf, 0);
      issue(4'd3, 64'd6, 1'b1);
      wait_done();

      // 9! = 362880 wraps to 35200 in 16 bits
      op16 = 4'd9;
      v16  = 1'b1;
      t    = 0;
      while (!in_ready16 && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (t >= 100) chk("accept16_timeout", 1, 0);
      q16.push_back('{64'd35200, OVF_EN, cyc + 1, 9});
      @(negedge clk);
      v16 = 1'b0;
      t   = 0;
      while (!out_valid16 && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (t >= 100) chk("done16_timeout", 1, 0);

      repeat (5) @(negedge clk);
      chk("queue_empty", q.size() + q16.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
